// File: rtl/gray_decoder_monitor.sv
// gray_decoder_monitor
// Receive side for a gray-coded counter: decodes each valid sample to binary
// through a two-stage pipeline, classifies the step against the previous
// sample (hold/up/down/illegal), counts illegal steps and enters FAULT after
// ERR_LIMIT consecutive violations, leaving it after GOOD_LIMIT legal steps.
// Optional macro GRAY_DECODER_SYNC_EN inserts a 2-flop synchronizer on
// i_valid/i_gray ahead of stage 1 (adds two edges of latency).

module gray_decoder_monitor #(
    parameter int N          = 4,
    parameter int ERR_LIMIT  = 3,
    parameter int GOOD_LIMIT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [N-1:0]     i_gray,
    output logic             o_valid,
    output logic [N-1:0]     o_binary,
    output logic             o_up,
    output logic             o_down,
    output logic             o_hold,
    output logic             o_error,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int GOOD_W = $clog2(GOOD_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [ERR_W-1:0]    err_run, err_run_next;
    logic [GOOD_W-1:0]   good_run, good_run_next;

    logic                in_valid;
    logic [N-1:0]        in_gray;
    logic                s1_valid;
    logic [N-1:0]        s1_gray;
    logic [N-1:0]        s1_bin;
    logic [N-1:0]        prev_bin;
    logic [N-1:0]        delta;
    logic                step_hold, step_up, step_down, step_bad;
    logic                up_next, down_next, hold_next, error_next;

`ifdef GRAY_DECODER_SYNC_EN
    logic [1:0]          sync_valid;
    logic [N-1:0]        sync_gray_a, sync_gray_b;

    // Two-flop synchronizer for a gray count arriving from another domain
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_valid  <= '0;
            sync_gray_a <= '0;
            sync_gray_b <= '0;
        end else begin
            sync_valid  <= {sync_valid[0], i_valid};
            sync_gray_a <= i_gray;
            sync_gray_b <= sync_gray_a;
        end
    end

    assign in_valid = sync_valid[1];
    assign in_gray  = sync_gray_b;
`else
    assign in_valid = i_valid;
    assign in_gray  = i_gray;
`endif

    // Stage 1: capture the offered gray sample
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_gray  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_gray <= in_gray;
            end
        end
    end

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it
    always_comb begin
        s1_bin = '0;
        for (int i = 0; i < N; i++) begin
            s1_bin[i] = ^(s1_gray >> i);
        end
    end

    assign delta     = s1_bin - prev_bin;
    assign step_hold = (delta == '0);
    assign step_up   = (delta == N'(1));
    assign step_down = (delta == '1);
    assign step_bad  = !(step_hold || step_up || step_down);

    // Next-state and step flags; nothing moves unless stage 1 holds a sample
    always_comb begin
        state_next    = state;
        err_run_next  = err_run;
        good_run_next = good_run;
        up_next       = 1'b0;
        down_next     = 1'b0;
        hold_next     = 1'b0;
        error_next    = 1'b0;

        if (s1_valid) begin
            case (state)
                ST_EMPTY: begin
                    state_next = ST_LOCKED;
                end
                ST_LOCKED: begin
                    up_next    = step_up;
                    down_next  = step_down;
                    hold_next  = step_hold;
                    error_next = step_bad;
                    if (step_bad) begin
                        if (err_run == ERR_W'(ERR_LIMIT - 1)) begin
                            state_next    = ST_FAULT;
                            err_run_next  = '0;
                            good_run_next = '0;
                        end else begin
                            err_run_next = err_run + ERR_W'(1);
                        end
                    end else begin
                        err_run_next = '0;
                    end
                end
                ST_FAULT: begin
                    up_next    = step_up;
                    down_next  = step_down;
                    hold_next  = step_hold;
                    error_next = step_bad;
                    if (step_bad) begin
                        good_run_next = '0;
                    end else if (good_run == GOOD_W'(GOOD_LIMIT - 1)) begin
                        state_next    = ST_LOCKED;
                        err_run_next  = '0;
                        good_run_next = '0;
                    end else begin
                        good_run_next = good_run + GOOD_W'(1);
                    end
                end
                default: begin
                    state_next    = ST_EMPTY;
                    err_run_next  = '0;
                    good_run_next = '0;
                end
            endcase
        end
    end

    // Monitor state register and run counters
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_EMPTY;
            err_run  <= '0;
            good_run <= '0;
        end else begin
            state    <= state_next;
            err_run  <= err_run_next;
            good_run <= good_run_next;
        end
    end

    // Stage 2: decoded value, single-cycle step flags, reference and error total
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_binary    <= '0;
            o_up        <= 1'b0;
            o_down      <= 1'b0;
            o_hold      <= 1'b0;
            o_error     <= 1'b0;
            prev_bin    <= '0;
            o_err_count <= '0;
        end else begin
            o_valid <= s1_valid;
            o_up    <= up_next;
            o_down  <= down_next;
            o_hold  <= hold_next;
            o_error <= error_next;
            if (s1_valid) begin
                o_binary <= s1_bin;
                prev_bin <= s1_bin;
            end
            if (error_next && (o_err_count != {CNT_W{1'b1}})) begin
                o_err_count <= o_err_count + CNT_W'(1);
            end
        end
    end

    assign o_fault = (state == ST_FAULT);

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// tb_gray_decoder_monitor
// Randomized and directed stimulus against a behavioural model of the gray
// monitor. A second instance with CNT_W=2 exercises error-count saturation.
// Build with GRAY_DECODER_SYNC_EN defined to cover the synchronized variant.

module tb_gray_decoder_monitor;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;
`ifdef GRAY_DECODER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic         v;
        logic [N-1:0] g;
    } sample_t;

    logic         i_clk;
    logic         i_reset;
    logic         i_valid;
    logic [N-1:0] i_gray;

    logic         o_valid, o_up, o_down, o_hold, o_error, o_fault;
    logic [N-1:0] o_binary;
    logic [7:0]   o_err_count;

    logic         s_valid, s_up, s_down, s_hold, s_error, s_fault;
    logic [N-1:0] s_binary;
    logic [1:0]   s_err_count;

    int total = 0;
    int bad   = 0;

    sample_t hist[$];
    int  m_have, m_prev, m_err, m_err_run, m_good_run;
    bit  m_fault;

    logic         exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault;
    logic [N-1:0] exp_bin;
    logic [7:0]   exp_cnt;
    logic [1:0]   exp_cnt_sat;

    gray_decoder_monitor #(.N(N), .ERR_LIMIT(3), .GOOD_LIMIT(4), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_gray(i_gray),
        .o_valid(o_valid), .o_binary(o_binary), .o_up(o_up), .o_down(o_down),
        .o_hold(o_hold), .o_error(o_error), .o_fault(o_fault),
        .o_err_count(o_err_count)
    );

    gray_decoder_monitor #(.N(N), .ERR_LIMIT(3), .GOOD_LIMIT(4), .CNT_W(2)) dut_sat (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_gray(i_gray),
        .o_valid(s_valid), .o_binary(s_binary), .o_up(s_up), .o_down(s_down),
        .o_hold(s_hold), .o_error(s_error), .o_fault(s_fault),
        .o_err_count(s_err_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [N-1:0] to_gray(input int b);
        int x;
        x = (b ^ (b >> 1)) & MASK;
        return x[N-1:0];
    endfunction

    function automatic int decode(input int g);
        int b;
        int s;
        b = 0;
        s = g;
        while (s != 0) begin
            b = b ^ s;
            s = s >> 1;
        end
        return b & MASK;
    endfunction

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_err = 0;
        m_err_run = 0; m_good_run = 0; m_fault = 0;
        hist.delete();
        repeat (LAT + 1) hist.push_back('0);
    endtask

    task automatic model_apply(input sample_t s);
        int b;
        int d;
        exp_valid = s.v;
        exp_up = 0; exp_down = 0; exp_hold = 0; exp_error = 0;
        if (s.v) begin
            b = decode(int'(s.g));
            exp_bin = b[N-1:0];
            if (m_have != 0) begin
                d = (b - m_prev) & MASK;
                if (d == 0)         exp_hold = 1;
                else if (d == 1)    exp_up = 1;
                else if (d == MASK) exp_down = 1;
                else                exp_error = 1;
                if (exp_error) begin
                    m_err++;
                    if (!m_fault) begin
                        m_err_run++;
                        if (m_err_run >= 3) begin
                            m_fault = 1; m_good_run = 0;
                        end
                    end else begin
                        m_good_run = 0;
                    end
                end else if (!m_fault) begin
                    m_err_run = 0;
                end else begin
                    m_good_run++;
                    if (m_good_run >= 4) begin
                        m_fault = 0; m_err_run = 0; m_good_run = 0;
                    end
                end
            end
            m_have = 1;
            m_prev = b;
        end
        exp_fault   = m_fault;
        exp_cnt     = (m_err > 255) ? 8'd255 : 8'(m_err);
        exp_cnt_sat = (m_err > 3) ? 2'd3 : 2'(m_err);
    endtask

    // One clock: settle expectations for the sample now emerging, drive the next
    task automatic cycle(input logic v, input logic [N-1:0] g);
        sample_t s;
        @(negedge i_clk);
        s = hist.pop_front();
        model_apply(s);
        i_valid = v;
        i_gray  = g;
        hist.push_back({v, g});
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_gray  = '0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({o_valid, o_up, o_down, o_hold, o_error, o_fault} !== 6'b0) begin
            bad++; $display("[TB] FAIL reset_flags got=%b want=000000",
                            {o_valid, o_up, o_down, o_hold, o_error, o_fault});
        end
        total++;
        if (o_binary !== '0) begin
            bad++; $display("[TB] FAIL reset_binary got=%0d want=0", o_binary);
        end
        total++;
        if (o_err_count !== 8'd0 || s_err_count !== 2'd0) begin
            bad++; $display("[TB] FAIL reset_count got=%0d/%0d want=0/0", o_err_count, s_err_count);
        end
    endtask

    task automatic test_count_up();
        int seq[4] = '{0, 1, 3, 2};
        int first = -1;
        int ups = 0;
        do_reset();
        for (int j = 0; j < 4 + LAT + 2; j++) begin
            if (j < 4) cycle(1'b1, seq[j][N-1:0]);
            else       cycle(1'b0, '0);
            if (o_valid === 1'b1 && first < 0) first = j;
            if (o_up === 1'b1) ups++;
            total++;
            if ({o_valid, o_up, o_down, o_hold, o_error, o_fault} !==
                {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault}) begin
                bad++; $display("[TB] FAIL count_up_flags got=%b want=%b",
                    {o_valid, o_up, o_down, o_hold, o_error, o_fault},
                    {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault});
            end
            if (exp_valid) begin
                total++;
                if (o_binary !== exp_bin) begin
                    bad++; $display("[TB] FAIL count_up_binary got=%0d want=%0d", o_binary, exp_bin);
                end
            end
        end
        total++;
        if (first != LAT + 1) begin
            bad++; $display("[TB] FAIL latency got=%0d want=%0d", first, LAT + 1);
        end
        total++;
        if (ups != 3 || o_err_count !== 8'd0) begin
            bad++; $display("[TB] FAIL count_up_summary got=ups%0d/err%0d want=ups3/err0", ups, o_err_count);
        end
    endtask

    task automatic test_wrap();
        int seq[5] = '{14, 15, 0, 15, 15};
        int ups = 0, downs = 0, holds = 0;
        do_reset();
        for (int j = 0; j < 5 + LAT + 1; j++) begin
            if (j < 5) cycle(1'b1, to_gray(seq[j]));
            else       cycle(1'b0, '0);
            if (o_up === 1'b1)   ups++;
            if (o_down === 1'b1) downs++;
            if (o_hold === 1'b1) holds++;
            total++;
            if ({o_valid, o_up, o_down, o_hold, o_error, o_fault} !==
                {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault}) begin
                bad++; $display("[TB] FAIL wrap_flags got=%b want=%b",
                    {o_valid, o_up, o_down, o_hold, o_error, o_fault},
                    {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault});
            end
        end
        total++;
        if (ups != 2 || downs != 1 || holds != 1) begin
            bad++; $display("[TB] FAIL wrap_summary got=u%0d/d%0d/h%0d want=u2/d1/h1", ups, downs, holds);
        end
    endtask

    task automatic test_illegal();
        int seq[4] = '{0, 4, 2, 8};
        do_reset();
        for (int j = 0; j < 4 + LAT + 1; j++) begin
            if (j < 4) cycle(1'b1, to_gray(seq[j]));
            else       cycle(1'b0, '0);
            total++;
            if ({o_valid, o_up, o_down, o_hold, o_error, o_fault, o_err_count} !==
                {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault, exp_cnt}) begin
                bad++; $display("[TB] FAIL illegal_outputs got=%b/%0d want=%b/%0d",
                    {o_valid, o_up, o_down, o_hold, o_error, o_fault}, o_err_count,
                    {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault}, exp_cnt);
            end
        end
        total++;
        if (o_fault !== 1'b1 || o_err_count !== 8'd3) begin
            bad++; $display("[TB] FAIL illegal_summary got=f%0b/c%0d want=f1/c3", o_fault, o_err_count);
        end
    endtask

    task automatic test_recovery();
        int seq[14] = '{9, 10, 11, 11, 0, 6, 3, 4, 5, 9, 10, 11, 12, 13};
        logic [3:0] faults = '0;
        int nv = 0;
        for (int j = 0; j < 14 + LAT + 1; j++) begin
            if (j < 14) cycle(1'b1, to_gray(seq[j]));
            else        cycle(1'b0, '0);
            if (o_valid === 1'b1) begin
                if (nv < 4) faults[nv] = o_fault;
                nv++;
            end
            total++;
            if ({o_valid, o_up, o_down, o_hold, o_error, o_fault, o_err_count} !==
                {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault, exp_cnt}) begin
                bad++; $display("[TB] FAIL recovery_outputs got=%b/%0d want=%b/%0d",
                    {o_valid, o_up, o_down, o_hold, o_error, o_fault}, o_err_count,
                    {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault}, exp_cnt);
            end
        end
        total++;
        if (faults !== 4'b0111) begin
            bad++; $display("[TB] FAIL recovery_fault_trace got=%b want=0111", faults);
        end
        total++;
        if (o_fault !== 1'b0 || o_err_count !== 8'd7 || s_err_count !== 2'd3) begin
            bad++; $display("[TB] FAIL recovery_summary got=f%0b/c%0d/s%0d want=f0/c7/s3",
                            o_fault, o_err_count, s_err_count);
        end
    endtask

    task automatic test_random_gaps();
        int forced[5] = '{0, 5, 10, 15, 4};
        int cur = 4;
        int nb;
        int r;
        logic v;
        do_reset();
        for (int j = 0; j < 5; j++) cycle(1'b1, to_gray(forced[j]));
        for (int j = 0; j < 400 + LAT + 1; j++) begin
            nb = cur;
            v = (j < 400) && ($urandom_range(0, 3) != 0);
            if (v) begin
                r = $urandom_range(0, 9);
                if (r < 3)       nb = (cur + 1) & MASK;
                else if (r < 5)  nb = (cur - 1) & MASK;
                else if (r == 5) nb = cur;
                else             nb = $urandom_range(0, MASK);
                cur = nb;
            end
            cycle(v, v ? to_gray(nb) : N'($urandom_range(0, MASK)));
            total++;
            if ({o_valid, o_up, o_down, o_hold, o_error, o_fault, o_err_count} !==
                {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault, exp_cnt}) begin
                bad++; $display("[TB] FAIL random_outputs got=%b/%0d want=%b/%0d",
                    {o_valid, o_up, o_down, o_hold, o_error, o_fault}, o_err_count,
                    {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault}, exp_cnt);
            end
            total++;
            if ({s_valid, s_up, s_down, s_hold, s_error, s_fault, s_err_count} !==
                {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault, exp_cnt_sat}) begin
                bad++; $display("[TB] FAIL random_sat_outputs got=%b/%0d want=%b/%0d",
                    {s_valid, s_up, s_down, s_hold, s_error, s_fault}, s_err_count,
                    {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault}, exp_cnt_sat);
            end
            if (exp_valid) begin
                total++;
                if (o_binary !== exp_bin || s_binary !== exp_bin) begin
                    bad++; $display("[TB] FAIL random_binary got=%0d/%0d want=%0d", o_binary, s_binary, exp_bin);
                end
            end
        end
        total++;
        if (s_err_count !== 2'd3) begin
            bad++; $display("[TB] FAIL saturation got=%0d want=3", s_err_count);
        end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        int flagged = 0;
        do_reset();
        cycle(1'b1, to_gray(3));
        cycle(1'b1, to_gray(4));
        cycle(1'b1, to_gray(9));
        do_reset();
        total++;
        if (o_valid !== 1'b0 || o_err_count !== 8'd0) begin
            bad++; $display("[TB] FAIL midreset_clear got=v%0b/c%0d want=v0/c0", o_valid, o_err_count);
        end
        for (int j = 0; j < LAT + 3; j++) begin
            cycle(1'b0, '0);
            if (o_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("[TB] FAIL midreset_leak got=%0d want=0", seen);
        end
        seen = 0;
        for (int j = 0; j < LAT + 2; j++) begin
            if (j == 0) cycle(1'b1, to_gray(12));
            else        cycle(1'b0, '0);
            if (o_valid === 1'b1) begin
                seen++;
                if ({o_up, o_down, o_hold, o_error} !== 4'b0) flagged++;
            end
            total++;
            if ({o_valid, o_up, o_down, o_hold, o_error, o_fault} !==
                {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault}) begin
                bad++; $display("[TB] FAIL midreset_flags got=%b want=%b",
                    {o_valid, o_up, o_down, o_hold, o_error, o_fault},
                    {exp_valid, exp_up, exp_down, exp_hold, exp_error, exp_fault});
            end
        end
        total++;
        if (seen != 1 || flagged != 0) begin
            bad++; $display("[TB] FAIL midreset_first got=seen%0d/flag%0d want=seen1/flag0", seen, flagged);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_gray  = '0;
        model_reset();
        test_reset();
        test_count_up();
        test_wrap();
        test_illegal();
        test_recovery();
        test_random_gaps();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
